// File: rtl/nco_dac_pkg.sv
// Shared constants, FSM state type and sample conversion for the NCO -> SPI DAC path.
package nco_dac_pkg;

    localparam int         FRAME_W       = 24;
    localparam logic [3:0] DAC_CMD_WRUPD = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Two's complement to offset binary: flipping the sign bit maps -2048..2047 onto 0..4095.
    function automatic logic [11:0] to_offset_bin(input logic [11:0] s);
        return {~s[11], s[10:0]};
    endfunction

endpackage

// File: rtl/nco_dac_spi_tx_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; push and pop may occur together, even when full.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // Pointer update; the caller only pops when non-empty and only pushes when there is room.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/nco_dac_spi_tx.sv
// Buffers NCO samples and sends each one as a 24-bit SPI mode-0 write/update frame to a serial DAC.
module nco_dac_spi_tx
    import nco_dac_pkg::*;
#(
    parameter int         DATA_W   = 12,
    parameter int         CLK_DIV  = 4,
    parameter int         GAP_CYC  = 3,
    parameter int         FIFO_AW  = 2,
    parameter logic [3:0] DAC_ADDR = 4'h0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr_ovf,
    output logic              dac_sclk,
    output logic              dac_cs_n,
    output logic              dac_sdi,
    output logic              busy,
    output logic              overflow,
    output logic              frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div, div_nxt;
    logic [GAP_W-1:0]   gcnt, gcnt_nxt;
    logic [4:0]         bitc, bitc_nxt;
    logic [FRAME_W-2:0] shreg, shreg_nxt;   // bits still to send after the one on sdi
    logic               sclk_nxt, cs_n_nxt, sdi_nxt, done_nxt, ovf_nxt;

    logic               pop, push, drop, full, empty;
    logic [DATA_W-1:0]  fifo_wdata, fifo_rdata;
    logic [FRAME_W-1:0] frame;

    assign fifo_wdata = to_offset_bin(in_data);
    assign frame      = {DAC_CMD_WRUPD, DAC_ADDR, fifo_rdata[11:0], 4'b0000};

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;
    assign busy = (state != ST_IDLE) || !empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (fifo_wdata),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (full),
        .empty   (empty)
    );

    // State and SPI output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            div        <= '0;
            gcnt       <= '0;
            bitc       <= '0;
            shreg      <= '0;
            dac_sclk   <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sdi    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            gcnt       <= gcnt_nxt;
            bitc       <= bitc_nxt;
            shreg      <= shreg_nxt;
            dac_sclk   <= sclk_nxt;
            dac_cs_n   <= cs_n_nxt;
            dac_sdi    <= sdi_nxt;
            frame_done <= done_nxt;
            overflow   <= ovf_nxt;
        end
    end

    // Next-state logic: load on IDLE, shift on SCLK falling edges, hold cs_n high during GAP.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        gcnt_nxt  = gcnt;
        bitc_nxt  = bitc;
        shreg_nxt = shreg;
        sclk_nxt  = dac_sclk;
        cs_n_nxt  = dac_cs_n;
        sdi_nxt   = dac_sdi;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        // A drop sets the flag even when a clear is requested in the same cycle.
        ovf_nxt   = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow);

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_nxt = frame[FRAME_W-2:0];
                    sdi_nxt   = frame[FRAME_W-1];
                    cs_n_nxt  = 1'b0;
                    sclk_nxt  = 1'b0;
                    div_nxt   = '0;
                    bitc_nxt  = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div == DIV_W'(CLK_DIV - 1)) begin
                    div_nxt  = '0;
                    sclk_nxt = ~dac_sclk;
                    // Data only moves on the falling edge so the DAC sees it stable on the rise.
                    if (dac_sclk) begin
                        if (bitc == 5'(FRAME_W - 1)) begin
                            cs_n_nxt  = 1'b1;
                            sdi_nxt   = 1'b0;
                            done_nxt  = 1'b1;
                            gcnt_nxt  = '0;
                            state_nxt = ST_GAP;
                        end else begin
                            sdi_nxt   = shreg[FRAME_W-2];
                            shreg_nxt = {shreg[FRAME_W-3:0], 1'b0};
                            bitc_nxt  = bitc + 5'd1;
                        end
                    end
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == GAP_W'(GAP_CYC - 1)) state_nxt = ST_IDLE;
                else                             gcnt_nxt  = gcnt + 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nco_dac_spi_tx.sv
// Random and directed stimulus; a reference model predicts frames and flags, a negedge monitor checks them.
module tb_nco_dac_spi_tx;

    localparam int         CLK_DIV = 4;
    localparam int         GAP_CYC = 3;
    localparam int         DEPTH   = 4;
    localparam logic [3:0] DADDR   = 4'h0;
    localparam int         CS_LOW  = 48 * CLK_DIV;
    localparam int         PERIOD  = CS_LOW + GAP_CYC + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        clr_ovf = 1'b0;
    logic        dac_sclk, dac_cs_n, dac_sdi, busy, overflow, frame_done;

    always #5 clk = ~clk;

    nco_dac_spi_tx #(
        .DATA_W   (12),
        .CLK_DIV  (CLK_DIV),
        .GAP_CYC  (GAP_CYC),
        .FIFO_AW  (2),
        .DAC_ADDR (DADDR)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clr_ovf    (clr_ovf),
        .dac_sclk   (dac_sclk),
        .dac_cs_n   (dac_cs_n),
        .dac_sdi    (dac_sdi),
        .busy       (busy),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [23:0] frame;
        int          start;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        exq[$];
    logic [11:0] mq[$];
    int          cyc = 0;
    int          next_free = 0;
    bit          ovf_m = 1'b0;
    bit          busy_m = 1'b0;
    bit          dropped;
    exp_t        ent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected frame from the signed sample value: offset code = value + 2048.
    function automatic logic [23:0] mk_frame(input logic [11:0] s);
        int          c;
        logic [11:0] code;
        c    = int'($signed(s)) + 2048;
        code = 12'(c);
        return {4'b0011, DADDR, code, 4'b0000};
    endfunction

    // Reference model: a 4-deep queue drained by a transmitter that takes a
    // sample whenever it has been free for a full frame period.
    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            exq.delete();
            next_free = cyc + 1;
            ovf_m     = 1'b0;
        end else begin
            if (cyc >= next_free && mq.size() > 0) begin
                ent.frame = mk_frame(mq.pop_front());
                ent.start = cyc;
                exq.push_back(ent);
                next_free = cyc + PERIOD;
            end
            dropped = 1'b0;
            if (in_valid) begin
                if (mq.size() < DEPTH) mq.push_back(in_data);
                else                   dropped = 1'b1;
            end
            if (dropped)      ovf_m = 1'b1;
            else if (clr_ovf) ovf_m = 1'b0;
        end
        busy_m = (cyc < next_free - 1) || (mq.size() > 0);
        cyc++;
    end

    // Monitor: capture sdi on sclk rises while cs_n is low, compare each finished frame.
    bit          last_rst_n = 1'b0;
    bit          prev_cs = 1'b1;
    bit          prev_sclk = 1'b0;
    bit          active = 1'b0;
    int          nbits = 0;
    int          low = 0;
    int          fall_e = 0;
    logic [23:0] data = '0;
    exp_t        got;

    always @(negedge clk) begin
        if (!last_rst_n) begin
            chk("rst_cs_n", dac_cs_n, 1);
            chk("rst_sclk", dac_sclk, 0);
            chk("rst_sdi", dac_sdi, 0);
            chk("rst_busy", busy, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_frame_done", frame_done, 0);
            active = 1'b0;
            nbits  = 0;
        end else begin
            chk("overflow", overflow, ovf_m);
            chk("busy", busy, busy_m);
            if (!dac_cs_n && prev_cs) begin
                active = 1'b1;
                nbits  = 0;
                low    = 0;
                data   = '0;
                fall_e = cyc - 1;
            end
            if (!dac_cs_n) begin
                low++;
                if (dac_sclk && !prev_sclk) begin
                    data = {data[22:0], dac_sdi};
                    nbits++;
                end
            end else if (dac_sclk) begin
                chk("sclk_idle_low", dac_sclk, 0);
            end
            if (dac_cs_n && !prev_cs) begin
                chk("frame_done_at_end", frame_done, 1);
                chk("frame_expected", exq.size() > 0, 1);
                if (exq.size() > 0) begin
                    got = exq.pop_front();
                    chk("frame_data", data, got.frame);
                    chk("frame_bits", nbits, 24);
                    chk("cs_low_cycles", low, CS_LOW);
                    chk("frame_start", fall_e, got.start);
                end
                active = 1'b0;
            end else if (frame_done) begin
                chk("frame_done_spurious", frame_done, 0);
            end
        end
        prev_cs    = dac_cs_n;
        prev_sclk  = dac_sclk;
        last_rst_n = reset_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = 12'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exq.size() > 0 || mq.size() > 0 || busy_m) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    task automatic burst6(input bit clr_last);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            clr_ovf  = clr_last && (i == 5);
            step();
        end
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        send(12'h000);
        drain(1000);
        send(12'h800);
        drain(1000);
        send(12'h7FF);
        drain(1000);

        burst6(1'b0);
        chk("burst_overflow", overflow, 1);
        drain(1500);

        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf_alone", overflow, 0);

        burst6(1'b1);
        chk("clr_with_drop", overflow, 1);
        drain(1500);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        send(12'($urandom));
        n = 0;
        while (!(active && nbits >= 11) && n < 500) begin
            step();
            n++;
        end
        chk("reach_bit10", n < 500, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst_cs_n", dac_cs_n, 1);
        chk("midrst_sclk", dac_sclk, 0);
        chk("midrst_busy", busy, 0);
        step();
        send(12'($urandom));
        drain(1000);

        for (int i = 0; i < 4000; i++) begin
            in_valid = ($urandom_range(0, 99) < 2);
            in_data  = 12'($urandom);
            clr_ovf  = ($urandom_range(0, 99) == 0);
            step();
        end
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        drain(2000);
        chk("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
